// File: rtl/nt_mon_pkg.sv
// nt_mon_pkg: shared state encoding, cause codes and default parameters for the trigger monitor
package nt_mon_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ALARM = 2'd2
    } state_t;
    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_THR  = 2'b01;
    localparam logic [1:0] CAUSE_PAT  = 2'b10;
    localparam logic [1:0] CAUSE_BOTH = 2'b11;
    localparam int DEF_WINDOW  = 16;
    localparam int DEF_THRESH  = 4;
    localparam int DEF_PAT_LEN = 4;
    localparam int DEF_CNT_W   = 5;
    localparam logic [7:0] DEF_PATTERN = 8'b0000_1011;
endpackage

// File: rtl/nt_edge_pattern_det.sv
// nt_edge_pattern_det: valid-gated rising-edge and bit-pattern detection on the observed stream
module nt_edge_pattern_det
    import nt_mon_pkg::*;
#(
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN)
) (
    input  logic clk,
    input  logic rst,
    input  logic in_bit,
    input  logic in_valid,
    input  logic hold,
    input  logic clr,
    output logic rise,
    output logic match
);
    localparam int SW = PAT_LEN - 1;
    logic prev_bit;
    logic [SW-1:0] sr;
    assign rise  = in_valid & in_bit & ~prev_bit;
    assign match = in_valid & ({sr, in_bit} == PATTERN);
    // history of valid samples; frozen while the alarm is pending, wiped on reset or ack
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            prev_bit <= 1'b0;
            sr       <= '0;
        end else if (in_valid && !hold) begin
            prev_bit <= in_bit;
            sr       <= SW'({sr, in_bit});
        end
    end
endmodule

// File: rtl/nt_trigger_monitor.sv
// nt_trigger_monitor: sticky alarm on edge bursts within a sample window or on a fixed bit pattern
module nt_trigger_monitor
    import nt_mon_pkg::*;
#(
    parameter int WINDOW  = DEF_WINDOW,
    parameter int THRESH  = DEF_THRESH,
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             I1470,
    input  logic             I1477,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             alarm_ack,
    output logic             alarm,
    output logic [1:0]       alarm_cause,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [1:0]       state
);
    localparam int WW = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);
    localparam logic [WW-1:0] WEND = WW'(WINDOW);
    state_t st;
    logic [WW-1:0] win, win_inc;
    logic [CNT_W-1:0] base, inc, edge_nxt;
    logic rise, match, thr, trig, acked;
    assign state = st;
    assign acked = (st == ALARM) && alarm_ack;
    nt_edge_pattern_det #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN)) u_det (
        .clk(I1470),
        .rst(I1477),
        .in_bit(in_bit),
        .in_valid(in_valid),
        .hold(st == ALARM),
        .clr(acked),
        .rise(rise),
        .match(match)
    );
    // count edges from zero when idle, saturating; threshold is judged on the incoming rise
    always_comb begin
        base     = (st == ARMED) ? edge_cnt : '0;
        inc      = (&base) ? base : base + CNT_W'(1);
        edge_nxt = rise ? inc : base;
        thr      = rise & (inc >= THR);
        trig     = thr | match;
        win_inc  = win + WW'(1);
    end
    // monitor FSM: a trigger beats window expiry; alarm held until acked while in ALARM
    always_ff @(posedge I1470) begin
        if (I1477 || acked) begin
            st          <= IDLE;
            alarm       <= 1'b0;
            alarm_cause <= CAUSE_NONE;
            edge_cnt    <= '0;
            win         <= '0;
        end else if (in_valid && st != ALARM) begin
            edge_cnt <= edge_nxt;
            win      <= (st == ARMED) ? win_inc : WW'(rise);
            if (trig) begin
                st          <= ALARM;
                alarm       <= 1'b1;
                alarm_cause <= (thr ? CAUSE_THR : CAUSE_NONE) | (match ? CAUSE_PAT : CAUSE_NONE);
            end else if (st == ARMED && win_inc == WEND) begin
                st       <= IDLE;
                edge_cnt <= '0;
                win      <= '0;
            end else if (rise) begin
                st <= ARMED;
            end
        end
    end
endmodule
